// File: rtl/wb_arbiter_pkg.sv
// Shared types and default sizing for the write-back arbiter.
// The FIFO entry pairs an SRAM write address with its pooled data word.
package wb_arbiter_pkg;

    localparam int WB_SA_NUM       = 4;
    localparam int SA_OUTPUT_WIDTH = 16;
    localparam int SRAM_ADDR_SIZE  = 10;
    localparam int WB_FIFO_DEPTH   = 4;

    typedef struct packed {
        logic [SRAM_ADDR_SIZE-1:0]  addr;
        logic [SA_OUTPUT_WIDTH-1:0] data;
    } wb_entry_t;

endpackage

// File: rtl/wb_fifo.sv
// Per-stream synchronous FIFO of write-back entries.
// A push into an empty FIFO is not visible at the output until the next cycle.
module wb_fifo
    import wb_arbiter_pkg::*;
#(
    parameter int DEPTH = WB_FIFO_DEPTH
)(
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push,
    input  logic                   pop,
    input  wb_entry_t              wr_entry,
    output wb_entry_t              rd_entry,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [PW-1:0] PTR_ONE = PW'(1);
    localparam logic [PW:0]   CNT_ONE = (PW+1)'(1);

    wb_entry_t     mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW:0]   count_q, count_d;
    logic          push_ok, pop_ok;

    assign full     = (count_q == (PW+1)'(DEPTH));
    assign empty    = (count_q == '0);
    assign count    = count_q;
    assign rd_entry = mem_q[rd_ptr_q];

    // A full FIFO still takes the push when the same edge frees a slot.
    assign pop_ok  = pop && !empty;
    assign push_ok = push && (!full || pop_ok);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) wr_ptr_d = wr_ptr_q + PTR_ONE;
        if (pop_ok)  rd_ptr_d = rd_ptr_q + PTR_ONE;
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= wr_entry;
    end

endmodule

// File: rtl/wb_arbiter.sv
// Buffers one result stream per systolic array and round-robins them onto
// the single SRAM write port through a one-entry output register.
module wb_arbiter
    import wb_arbiter_pkg::*;
#(
    parameter int SA_NUM     = WB_SA_NUM,
    parameter int FIFO_DEPTH = WB_FIFO_DEPTH
)(
    input  logic                              clk,
    input  logic                              reset,
    input  logic [SA_NUM-1:0]                 wb_valid,
    input  logic [SA_NUM*SA_OUTPUT_WIDTH-1:0] wb_data,
    input  logic [SA_NUM*SRAM_ADDR_SIZE-1:0]  wb_addr,
    input  logic                              sram_ready,
    input  logic                              clear_err,
    output logic                              sram_wr_en,
    output logic [SRAM_ADDR_SIZE-1:0]         sram_wr_addr,
    output logic [SA_OUTPUT_WIDTH-1:0]        sram_wr_data,
    output logic [SA_NUM-1:0]                 fifo_full,
    output logic [SA_NUM-1:0]                 overflow,
    output logic                              idle
);

    localparam int IW = (SA_NUM > 1) ? $clog2(SA_NUM) : 1;
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    wb_entry_t                  head [SA_NUM];
    logic [CW-1:0]              fifo_count [SA_NUM];
    logic [SA_NUM-1:0]          fifo_empty;
    logic [SA_NUM-1:0]          pop;

    logic                       wr_en_q, wr_en_d;
    logic [SRAM_ADDR_SIZE-1:0]  wr_addr_q, wr_addr_d;
    logic [SA_OUTPUT_WIDTH-1:0] wr_data_q, wr_data_d;
    logic [IW-1:0]              rr_q, rr_d;
    logic [SA_NUM-1:0]          overflow_q, overflow_d;

    logic                       can_load;
    logic                       gnt_valid;
    logic [IW-1:0]              gnt_idx;
    logic [IW-1:0]              idx;
    int                         sum;
    logic                       all_empty;

    genvar g;
    generate
        for (g = 0; g < SA_NUM; g++) begin : g_fifo
            wb_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
                .clk      (clk),
                .reset    (reset),
                .push     (wb_valid[g]),
                .pop      (pop[g]),
                .wr_entry ({wb_addr[g*SRAM_ADDR_SIZE +: SRAM_ADDR_SIZE],
                            wb_data[g*SA_OUTPUT_WIDTH +: SA_OUTPUT_WIDTH]}),
                .rd_entry (head[g]),
                .full     (fifo_full[g]),
                .empty    (fifo_empty[g]),
                .count    (fifo_count[g])
            );
        end
    endgenerate

    assign can_load = !wr_en_q || sram_ready;

    // Search starts just after the last winner so every stream gets a turn.
    always_comb begin
        gnt_valid = 1'b0;
        gnt_idx   = rr_q;
        idx       = '0;
        sum       = 0;
        for (int k = 1; k <= SA_NUM; k++) begin
            sum = int'(rr_q) + k;
            if (sum >= SA_NUM) sum = sum - SA_NUM;
            idx = IW'(sum);
            if (!gnt_valid && !fifo_empty[idx]) begin
                gnt_valid = 1'b1;
                gnt_idx   = idx;
            end
        end
    end

    always_comb begin
        pop = '0;
        if (can_load && gnt_valid) pop[gnt_idx] = 1'b1;
    end

    always_comb begin
        wr_en_d   = wr_en_q;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        rr_d      = rr_q;
        if (can_load) begin
            wr_en_d = gnt_valid;
            if (gnt_valid) begin
                wr_addr_d = head[gnt_idx].addr;
                wr_data_d = head[gnt_idx].data;
                rr_d      = gnt_idx;
            end
        end
        // A drop on the clearing edge wins over the clear.
        overflow_d = (clear_err ? '0 : overflow_q) | (wb_valid & fifo_full & ~pop);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_en_q    <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
            rr_q       <= IW'(SA_NUM - 1);
            overflow_q <= '0;
        end else begin
            wr_en_q    <= wr_en_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
            rr_q       <= rr_d;
            overflow_q <= overflow_d;
        end
    end

    always_comb begin
        all_empty = 1'b1;
        for (int i = 0; i < SA_NUM; i++) begin
            if (fifo_count[i] != '0) all_empty = 1'b0;
        end
    end

    assign sram_wr_en   = wr_en_q;
    assign sram_wr_addr = wr_addr_q;
    assign sram_wr_data = wr_data_q;
    assign overflow     = overflow_q;
    assign idle         = all_empty && !wr_en_q;

endmodule
